// File: rtl/uparc_cpu_busarb.sv
// uparc_cpu_busarb: merges the CPU instruction fetch port and data port onto
// one system bus with a single outstanding transaction. Requests are captured
// into per-port pending registers, granted round-robin from IDLE, and the
// response (or a timeout error) is routed back to the owning port.
//
// Handshake: every command, Rdy and Err signal is a single-cycle pulse. A port
// may have at most one request outstanding; it may issue the next request
// only after it has seen its own Rdy or Err pulse. Commands that arrive while
// the same port is already pending or in flight are dropped. o_busy exposes
// the FSM state (1 = WAIT).
module uparc_cpu_busarb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction port
  input  logic [ADDR_WIDTH-1:0] i_IAddr,
  input  logic                  i_IRdC,
  output logic [DATA_WIDTH-1:0] o_IData,
  output logic                  o_IRdy,
  output logic                  o_IErr,
  // data port
  input  logic [ADDR_WIDTH-1:0] i_DAddr,
  input  logic                  i_DCmd,
  input  logic                  i_DRnW,
  input  logic [BEN_WIDTH-1:0]  i_DBen,
  input  logic [DATA_WIDTH-1:0] i_DData,
  output logic [DATA_WIDTH-1:0] o_DData,
  output logic                  o_DRdy,
  output logic                  o_DErr,
  // system bus
  output logic [ADDR_WIDTH-1:0] o_BAddr,
  output logic                  o_BCmd,
  output logic                  o_BRnW,
  output logic [BEN_WIDTH-1:0]  o_BBen,
  output logic [DATA_WIDTH-1:0] o_BData,
  input  logic [DATA_WIDTH-1:0] i_BData,
  input  logic                  i_BRdy,
  input  logic                  i_BErr,
  output logic                  o_busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Port identifiers used for last_grant and the transaction owner.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic [CNT_W-1:0]      r_cnt;

  logic                  r_pend_i;
  logic [ADDR_WIDTH-1:0] r_i_addr;
  logic                  r_pend_d;
  logic [ADDR_WIDTH-1:0] r_d_addr;
  logic                  r_d_rnw;
  logic [BEN_WIDTH-1:0]  r_d_ben;
  logic [DATA_WIDTH-1:0] r_d_data;

  logic [ADDR_WIDTH-1:0] r_baddr;
  logic                  r_bcmd;
  logic                  r_brnw;
  logic [BEN_WIDTH-1:0]  r_bben;
  logic [DATA_WIDTH-1:0] r_bdata;
  logic [DATA_WIDTH-1:0] r_idata;
  logic                  r_irdy;
  logic                  r_ierr;
  logic [DATA_WIDTH-1:0] r_ddata;
  logic                  r_drdy;
  logic                  r_derr;

  logic                  w_idle;
  logic                  w_cand_i;
  logic                  w_cand_d;
  logic                  w_grant;
  logic                  w_grant_d;
  logic                  w_i_inflight;
  logic                  w_d_inflight;
  logic                  w_cap_i;
  logic                  w_cap_d;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] w_i_addr;
  logic [ADDR_WIDTH-1:0] w_d_addr;
  logic                  w_d_rnw;
  logic [BEN_WIDTH-1:0]  w_d_ben;
  logic [DATA_WIDTH-1:0] w_d_data;

  // Candidate selection, round-robin grant and same-cycle request bypass.
  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_cand_i     = r_pend_i | i_IRdC;
    w_cand_d     = r_pend_d | i_DCmd;
    w_grant      = w_idle & (w_cand_i | w_cand_d);
    // D wins when it is alone or when the tie-breaker says I went last.
    w_grant_d    = w_cand_d & (~w_cand_i | (r_last_grant == PORT_I));
    w_i_inflight = (r_state == S_WAIT) & (r_owner == PORT_I);
    w_d_inflight = (r_state == S_WAIT) & (r_owner == PORT_D);
    w_cap_i      = i_IRdC & ~r_pend_i & ~w_i_inflight;
    w_cap_d      = i_DCmd & ~r_pend_d & ~w_d_inflight;
    w_timeout    = (TIMEOUT_CYCLES != 0) & (r_cnt == TO_LAST_C);
    w_i_addr     = r_pend_i ? r_i_addr : i_IAddr;
    w_d_addr     = r_pend_d ? r_d_addr : i_DAddr;
    w_d_rnw      = r_pend_d ? r_d_rnw  : i_DRnW;
    w_d_ben      = r_pend_d ? r_d_ben  : i_DBen;
    w_d_data     = r_pend_d ? r_d_data : i_DData;
  end

  // Pending-request capture; the granted port's flag clears on its grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_i <= 1'b0;
      r_i_addr <= '0;
      r_pend_d <= 1'b0;
      r_d_addr <= '0;
      r_d_rnw  <= 1'b0;
      r_d_ben  <= '0;
      r_d_data <= '0;
    end else begin
      if (w_grant && !w_grant_d) begin
        r_pend_i <= 1'b0;
      end else if (w_cap_i) begin
        r_pend_i <= 1'b1;
        r_i_addr <= i_IAddr;
      end
      if (w_grant && w_grant_d) begin
        r_pend_d <= 1'b0;
      end else if (w_cap_d) begin
        r_pend_d <= 1'b1;
        r_d_addr <= i_DAddr;
        r_d_rnw  <= i_DRnW;
        r_d_ben  <= i_DBen;
        r_d_data <= i_DData;
      end
    end
  end

  // Bus FSM: issue the granted request, then wait for response or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= PORT_I;
      r_owner      <= PORT_I;
      r_cnt        <= '0;
      r_baddr      <= '0;
      r_bcmd       <= 1'b0;
      r_brnw       <= 1'b0;
      r_bben       <= '0;
      r_bdata      <= '0;
      r_idata      <= '0;
      r_irdy       <= 1'b0;
      r_ierr       <= 1'b0;
      r_ddata      <= '0;
      r_drdy       <= 1'b0;
      r_derr       <= 1'b0;
    end else begin
      r_bcmd <= 1'b0;
      r_irdy <= 1'b0;
      r_ierr <= 1'b0;
      r_drdy <= 1'b0;
      r_derr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_bcmd  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT;
            // The tie-breaker only moves when both ports competed.
            if (w_cand_i && w_cand_d) begin
              r_last_grant <= w_grant_d;
            end
            r_owner <= w_grant_d;
            if (w_grant_d) begin
              r_baddr <= w_d_addr;
              r_brnw  <= w_d_rnw;
              r_bben  <= w_d_ben;
              r_bdata <= w_d_data;
            end else begin
              r_baddr <= w_i_addr;
              r_brnw  <= 1'b1;
              r_bben  <= {BEN_WIDTH{1'b1}};
              r_bdata <= '0;
            end
          end
        end
        S_WAIT: begin
          if (i_BErr || (!i_BRdy && w_timeout)) begin
            r_ierr  <= (r_owner == PORT_I);
            r_derr  <= (r_owner == PORT_D);
            r_state <= S_IDLE;
          end else if (i_BRdy) begin
            if (r_owner == PORT_I) begin
              r_irdy  <= 1'b1;
              r_idata <= i_BData;
            end else begin
              r_drdy  <= 1'b1;
              r_ddata <= i_BData;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_BAddr = r_baddr;
  assign o_BCmd  = r_bcmd;
  assign o_BRnW  = r_brnw;
  assign o_BBen  = r_bben;
  assign o_BData = r_bdata;
  assign o_IData = r_idata;
  assign o_IRdy  = r_irdy;
  assign o_IErr  = r_ierr;
  assign o_DData = r_ddata;
  assign o_DRdy  = r_drdy;
  assign o_DErr  = r_derr;
  assign o_busy  = (r_state == S_WAIT);

endmodule

// File: tb/tb_uparc_cpu_busarb.sv
// Directed testbench for uparc_cpu_busarb: fetch, write, tie-break,
// alternation, timeout, error priority and reset during a transaction.
module tb_uparc_cpu_busarb;

  logic        clk;
  logic        rst;
  logic [31:0] i_IAddr;
  logic        i_IRdC;
  logic [31:0] o_IData;
  logic        o_IRdy;
  logic        o_IErr;
  logic [31:0] i_DAddr;
  logic        i_DCmd;
  logic        i_DRnW;
  logic [3:0]  i_DBen;
  logic [31:0] i_DData;
  logic [31:0] o_DData;
  logic        o_DRdy;
  logic        o_DErr;
  logic [31:0] o_BAddr;
  logic        o_BCmd;
  logic        o_BRnW;
  logic [3:0]  o_BBen;
  logic [31:0] o_BData;
  logic [31:0] i_BData;
  logic        i_BRdy;
  logic        i_BErr;
  logic        o_busy;

  int n_checks;
  int n_errors;

  // bus-command monitor results and response pulse counters
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int n_irdy, n_ierr, n_drdy, n_derr;

  uparc_cpu_busarb #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst),
    .i_IAddr(i_IAddr), .i_IRdC(i_IRdC), .o_IData(o_IData), .o_IRdy(o_IRdy), .o_IErr(o_IErr),
    .i_DAddr(i_DAddr), .i_DCmd(i_DCmd), .i_DRnW(i_DRnW), .i_DBen(i_DBen), .i_DData(i_DData),
    .o_DData(o_DData), .o_DRdy(o_DRdy), .o_DErr(o_DErr),
    .o_BAddr(o_BAddr), .o_BCmd(o_BCmd), .o_BRnW(o_BRnW), .o_BBen(o_BBen), .o_BData(o_BData),
    .i_BData(i_BData), .i_BRdy(i_BRdy), .i_BErr(i_BErr), .o_busy(o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // monitor sampled mid-cycle
  always @(negedge clk) begin
    if (o_BCmd) got_q.push_back(o_BAddr);
    if (o_IRdy) n_irdy++;
    if (o_IErr) n_ierr++;
    if (o_DRdy) n_drdy++;
    if (o_DErr) n_derr++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_d(input logic [31:0] addr, input logic rnw, input logic [3:0] ben,
                         input logic [31:0] data);
    i_DCmd  = 1'b1;
    i_DAddr = addr;
    i_DRnW  = rnw;
    i_DBen  = ben;
    i_DData = data;
  endtask

  int t;
  int s_irdy, s_ierr, s_drdy, s_derr;

  task automatic snap();
    s_irdy = n_irdy;
    s_ierr = n_ierr;
    s_drdy = n_drdy;
    s_derr = n_derr;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    n_irdy = 0; n_ierr = 0; n_drdy = 0; n_derr = 0;
    i_IAddr = '0; i_IRdC = 1'b0;
    i_DAddr = '0; i_DCmd = 1'b0; i_DRnW = 1'b0; i_DBen = '0; i_DData = '0;
    i_BData = '0; i_BRdy = 1'b0; i_BErr = 1'b0;
    do_reset();

    // reset state
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_bcmd", o_BCmd, 0);
    check_eq("rst_baddr", o_BAddr, 0);
    check_eq("rst_irdy", o_IRdy, 0);
    check_eq("rst_idata", o_IData, 0);

    // 1: instruction fetch
    i_IRdC = 1'b1; i_IAddr = 32'h100; exp_q.push_back(32'h100);
    step(); i_IRdC = 1'b0;
    check_eq("f_bcmd", o_BCmd, 1);
    check_eq("f_baddr", o_BAddr, 32'h100);
    check_eq("f_brnw", o_BRnW, 1);
    check_eq("f_bben", o_BBen, 4'hF);
    check_eq("f_bdata", o_BData, 0);
    check_eq("f_busy", o_busy, 1);
    step(); i_BRdy = 1'b1; i_BData = 32'hDEADBEEF;
    check_eq("f_bcmd_pulse", o_BCmd, 0);
    step(); i_BRdy = 1'b0;
    check_eq("f_irdy", o_IRdy, 1);
    check_eq("f_idata", o_IData, 32'hDEADBEEF);
    check_eq("f_drdy", o_DRdy, 0);
    check_eq("f_idle", o_busy, 0);
    step();
    check_eq("f_irdy_pulse", o_IRdy, 0);
    check_eq("f_idata_hold", o_IData, 32'hDEADBEEF);

    // 2: data write, plus an illegal re-issue while in flight
    drive_d(32'h2004, 1'b0, 4'b0011, 32'h1234); exp_q.push_back(32'h2004);
    step(); i_DCmd = 1'b0;
    check_eq("w_bcmd", o_BCmd, 1);
    check_eq("w_baddr", o_BAddr, 32'h2004);
    check_eq("w_brnw", o_BRnW, 0);
    check_eq("w_bben", o_BBen, 4'b0011);
    check_eq("w_bdata", o_BData, 32'h1234);
    step();
    drive_d(32'h9999, 1'b1, 4'hF, 32'h0);
    i_BRdy = 1'b1; i_BData = 32'h55;
    check_eq("w_baddr_hold", o_BAddr, 32'h2004);
    step(); i_BRdy = 1'b0; i_DCmd = 1'b0;
    check_eq("w_drdy", o_DRdy, 1);
    check_eq("w_irdy", o_IRdy, 0);
    step(); step(); step();
    check_eq("w_no_reissue", o_busy, 0);

    // 3: simultaneous requests after reset, D wins the tie
    do_reset();
    snap();
    i_IRdC = 1'b1; i_IAddr = 32'h300;
    drive_d(32'h400, 1'b1, 4'hF, 32'h0);
    exp_q.push_back(32'h400); exp_q.push_back(32'h300);
    step(); i_IRdC = 1'b0; i_DCmd = 1'b0;
    check_eq("tie_first_addr", o_BAddr, 32'h400);
    check_eq("tie_first_rnw", o_BRnW, 1);
    step(); i_BRdy = 1'b1; i_BData = 32'hA;
    step(); i_BRdy = 1'b0;
    check_eq("tie_drdy", o_DRdy, 1);
    check_eq("tie_ddata", o_DData, 32'hA);
    check_eq("tie_idle_gap", o_BCmd, 0);
    step();
    check_eq("tie_second_cmd", o_BCmd, 1);
    check_eq("tie_second_addr", o_BAddr, 32'h300);
    step(); i_BRdy = 1'b1; i_BData = 32'hB;
    step(); i_BRdy = 1'b0;
    check_eq("tie_irdy", o_IRdy, 1);
    check_eq("tie_idata", o_IData, 32'hB);
    step(); step();
    check_eq("tie_irdy_count", n_irdy - s_irdy, 1);
    check_eq("tie_drdy_count", n_drdy - s_drdy, 1);

    // 4: back-to-back requests from both ports alternate D,I,D,I...
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'hD00);
      exp_q.push_back(32'hA00);
    end
    i_IRdC = 1'b1; i_IAddr = 32'hA00;
    drive_d(32'hD00, 1'b1, 4'hF, 32'h0);
    step(); i_IRdC = 1'b0; i_DCmd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      t = 0;
      while (!o_BCmd && t < 20) begin
        step();
        t++;
      end
      check_eq("alt_bcmd_seen", o_BCmd, 1);
      step(); i_BRdy = 1'b1; i_BData = 32'hC0DE0000 + 32'(k);
      step(); i_BRdy = 1'b0;
      check_eq("alt_drdy", o_DRdy, (k % 2) == 0);
      check_eq("alt_irdy", o_IRdy, (k % 2) == 1);
      if (k < 6) begin
        if ((k % 2) == 0) drive_d(32'hD00, 1'b1, 4'hF, 32'h0);
        else i_IRdC = 1'b1;
        step(); i_IRdC = 1'b0; i_DCmd = 1'b0;
      end
    end
    step(); step();

    // 5: silent slave times out after 255 WAIT cycles; late response ignored
    snap();
    drive_d(32'h500, 1'b1, 4'hF, 32'h0); exp_q.push_back(32'h500);
    step(); i_DCmd = 1'b0;
    t = 1;
    while (!o_DErr && t < 300) begin
      step();
      t++;
    end
    check_eq("to_latency", t, 256);
    check_eq("to_derr", o_DErr, 1);
    check_eq("to_drdy", o_DRdy, 0);
    check_eq("to_idle", o_busy, 0);
    step(); step(); step();
    i_BRdy = 1'b1; i_BData = 32'hFFFF;
    step(); i_BRdy = 1'b0;
    step(); step();
    check_eq("to_late_drdy", n_drdy - s_drdy, 0);
    check_eq("to_late_irdy", n_irdy - s_irdy, 0);
    check_eq("to_derr_count", n_derr - s_derr, 1);

    // 6: Rdy and Err together -> error only, data held
    i_IRdC = 1'b1; i_IAddr = 32'h600; exp_q.push_back(32'h600);
    step(); i_IRdC = 1'b0;
    step(); i_BRdy = 1'b1; i_BErr = 1'b1; i_BData = 32'hBAD;
    step(); i_BRdy = 1'b0; i_BErr = 1'b0;
    check_eq("both_ierr", o_IErr, 1);
    check_eq("both_irdy", o_IRdy, 0);
    check_eq("both_idata_hold", o_IData, 32'hC0DE0007);
    check_eq("both_derr", o_DErr, 0);
    step();

    // 7: reset during WAIT, then a normal fetch
    drive_d(32'h700, 1'b1, 4'hF, 32'h0); exp_q.push_back(32'h700);
    step(); i_DCmd = 1'b0;
    check_eq("rw_busy", o_busy, 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    snap();
    check_eq("rw_busy_clr", o_busy, 0);
    check_eq("rw_idata_clr", o_IData, 0);
    i_BRdy = 1'b1; i_BData = 32'h77;
    step(); i_BRdy = 1'b0;
    step(); step();
    check_eq("rw_no_drdy", n_drdy - s_drdy, 0);
    check_eq("rw_no_derr", n_derr - s_derr, 0);
    i_IRdC = 1'b1; i_IAddr = 32'h800; exp_q.push_back(32'h800);
    step(); i_IRdC = 1'b0;
    check_eq("rw_bcmd", o_BCmd, 1);
    check_eq("rw_baddr", o_BAddr, 32'h800);
    step(); i_BRdy = 1'b1; i_BData = 32'h88;
    step(); i_BRdy = 1'b0;
    check_eq("rw_irdy", o_IRdy, 1);
    check_eq("rw_idata", o_IData, 32'h88);
    step(); step();

    // scoreboard: every bus command in order
    check_eq("bcmd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq("bcmd_addr", got_q[i], exp_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
